// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared op enum, opcode/funct codes and buffer sizing for the instruction encoder
package instr_pkg;

   localparam int INST_W     = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

   // request operation; 31 is deliberately left unassigned and is rejected
   typedef enum logic [4:0] {
      OP_NOP   = 5'd0,
      OP_ADD   = 5'd1,
      OP_ADDU  = 5'd2,
      OP_SUB   = 5'd3,
      OP_SUBU  = 5'd4,
      OP_AND   = 5'd5,
      OP_OR    = 5'd6,
      OP_XOR   = 5'd7,
      OP_NOR   = 5'd8,
      OP_SLT   = 5'd9,
      OP_SLTU  = 5'd10,
      OP_SLL   = 5'd11,
      OP_SRL   = 5'd12,
      OP_SRA   = 5'd13,
      OP_JR    = 5'd14,
      OP_JALR  = 5'd15,
      OP_LW    = 5'd16,
      OP_SW    = 5'd17,
      OP_LUI   = 5'd18,
      OP_ADDI  = 5'd19,
      OP_ADDIU = 5'd20,
      OP_ANDI  = 5'd21,
      OP_ORI   = 5'd22,
      OP_SLTI  = 5'd23,
      OP_SLTIU = 5'd24,
      OP_BEQ   = 5'd25,
      OP_BNE   = 5'd26,
      OP_BLEZ  = 5'd27,
      OP_BGTZ  = 5'd28,
      OP_J     = 5'd29,
      OP_JAL   = 5'd30
   } op_t;

   localparam logic [4:0] OP_ILLEGAL = 5'd31;

   // primary opcodes
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2b;
   localparam logic [5:0] OPC_LUI   = 6'h0f;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_ANDI  = 6'h0c;
   localparam logic [5:0] OPC_ORI   = 6'h0d;
   localparam logic [5:0] OPC_SLTI  = 6'h0a;
   localparam logic [5:0] OPC_SLTIU = 6'h0b;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_BLEZ  = 6'h06;
   localparam logic [5:0] OPC_BGTZ  = 6'h07;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;

   // R-type function codes
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;

   function automatic logic [INST_W-1:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                                input logic [4:0] rd, input logic [4:0] shamt,
                                                input logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [INST_W-1:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                                input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   function automatic logic [INST_W-1:0] j_word(input logic [5:0] opc, input logic [25:0] target);
      return {opc, target};
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - 4-entry word buffer between the encoder and instruction memory
module instr_fifo
   import instr_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [INST_W-1:0] push_data,
   input  logic              pop,
   output logic [INST_W-1:0] head,
   output logic [CNT_W-1:0]  count
);

   logic [INST_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   // guard against overflow/underflow even if the caller does not
   assign do_push = push && (count < FIFO_FULL);
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // storage, pointers and occupancy; reset wipes contents so head reads zero until the first push
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction requests into 32-bit words and streams them to instruction memory
module instr_encoder
   import instr_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [31:0]       out_addr,
   output logic [CNT_W-1:0]  count,
   output logic              err
);

   op_t               op;
   logic [INST_W-1:0] enc_word;
   logic              enc_legal;
   logic              accept;
   logic              push;
   logic              pop;

   assign op = op_t'(in_op);

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready  = (count < FIFO_FULL);
   assign accept    = in_valid && in_ready;
   assign push      = accept && enc_legal;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;

   // field packing; fields an instruction does not use are forced to zero
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (op)
         OP_NOP:   enc_word = '0;
         OP_ADD:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_ADD);
         OP_ADDU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_ADDU);
         OP_SUB:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_SUB);
         OP_SUBU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_SUBU);
         OP_AND:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_AND);
         OP_OR:    enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_OR);
         OP_XOR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_XOR);
         OP_NOR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_NOR);
         OP_SLT:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_SLT);
         OP_SLTU:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_SLTU);
         OP_SLL:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, FN_SLL);
         OP_SRL:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, FN_SRL);
         OP_SRA:   enc_word = r_word(5'd0, in_rt, in_rd, in_shamt, FN_SRA);
         OP_JR:    enc_word = r_word(in_rs, 5'd0, 5'd0, 5'd0, FN_JR);
         OP_JALR:  enc_word = r_word(in_rs, 5'd0, in_rd, 5'd0, FN_JALR);
         OP_LW:    enc_word = i_word(OPC_LW,    in_rs, in_rt, in_imm);
         OP_SW:    enc_word = i_word(OPC_SW,    in_rs, in_rt, in_imm);
         OP_LUI:   enc_word = i_word(OPC_LUI,   5'd0,  in_rt, in_imm);
         OP_ADDI:  enc_word = i_word(OPC_ADDI,  in_rs, in_rt, in_imm);
         OP_ADDIU: enc_word = i_word(OPC_ADDIU, in_rs, in_rt, in_imm);
         OP_ANDI:  enc_word = i_word(OPC_ANDI,  in_rs, in_rt, in_imm);
         OP_ORI:   enc_word = i_word(OPC_ORI,   in_rs, in_rt, in_imm);
         OP_SLTI:  enc_word = i_word(OPC_SLTI,  in_rs, in_rt, in_imm);
         OP_SLTIU: enc_word = i_word(OPC_SLTIU, in_rs, in_rt, in_imm);
         OP_BEQ:   enc_word = i_word(OPC_BEQ,   in_rs, in_rt, in_imm);
         OP_BNE:   enc_word = i_word(OPC_BNE,   in_rs, in_rt, in_imm);
         OP_BLEZ:  enc_word = i_word(OPC_BLEZ,  in_rs, 5'd0,  in_imm);
         OP_BGTZ:  enc_word = i_word(OPC_BGTZ,  in_rs, 5'd0,  in_imm);
         OP_J:     enc_word = j_word(OPC_J,   in_target);
         OP_JAL:   enc_word = j_word(OPC_JAL, in_target);
         default:  enc_legal = 1'b0;
      endcase
   end

   instr_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (enc_word),
      .pop       (pop),
      .head      (out_inst),
      .count     (count)
   );

   // byte address of the head word; advances one word per memory write and wraps at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         out_addr <= '0;
      end else if (pop) begin
         out_addr <= out_addr + 32'd4;
      end
   end

   // one-cycle flag for an accepted request carrying the unassigned op code
   always_ff @(posedge clk) begin
      if (reset) begin
         err <= 1'b0;
      end else begin
         err <= accept && !enc_legal;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;
   import instr_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_op = '0;
   logic [4:0]  in_rs = '0;
   logic [4:0]  in_rt = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_shamt = '0;
   logic [15:0] in_imm = '0;
   logic [25:0] in_target = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_addr;
   logic [2:0]  count;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   instr_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_shamt  (in_shamt),
      .in_imm    (in_imm),
      .in_target (in_target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_addr  (out_addr),
      .count     (count),
      .err       (err)
   );

   always #5 clk = ~clk;

   // hard stop in case something stalls the run
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic set_req(input op_t op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] shamt,
                          input logic [15:0] imm, input logic [25:0] target);
      in_valid  = 1'b1;
      in_op     = op;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_shamt  = shamt;
      in_imm    = imm;
      in_target = target;
   endtask

   op_t         vec_op  [17];
   logic [31:0] vec_exp [17];
   logic [31:0] exp_addr;

   initial begin
      // common fields: rs=1 rt=2 rd=3 shamt=4 imm=0x1234 target=0x3ABCDEF
      vec_op  = '{OP_ADD, OP_SUB, OP_NOR, OP_SLTU, OP_SLL, OP_SRA, OP_JR, OP_JALR, OP_NOP,
                  OP_SW, OP_LUI, OP_ORI, OP_BGTZ, OP_BNE, OP_SLTIU, OP_JAL, OP_XOR};
      vec_exp = '{32'h00221820, 32'h00221822, 32'h00221827, 32'h0022182B, 32'h00021900,
                  32'h00021903, 32'h00200008, 32'h00201809, 32'h00000000,
                  32'hAC221234, 32'h3C021234, 32'h34221234, 32'h1C201234, 32'h14221234,
                  32'h2C221234, 32'h0FABCDEF, 32'h00221826};

      step();
      do_reset();
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_addr", out_addr, 32'h0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_inst", out_inst, 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // ADDU with a nonzero shamt that must be dropped; latency one cycle
      set_req(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);
      step();
      in_valid = 1'b0;
      check("addu_valid", 32'(out_valid), 32'd1);
      check("addu_inst", out_inst, 32'h00221821);
      check("addu_addr", out_addr, 32'h0);
      check("addu_count", 32'(count), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("addu_pop_count", 32'(count), 32'd0);
      check("addu_pop_addr", out_addr, 32'h4);

      // LW then J back to back
      do_reset();
      set_req(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'h0);
      step();
      set_req(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
      step();
      in_valid = 1'b0;
      check("lwj_count", 32'(count), 32'd2);
      check("lw_inst", out_inst, 32'h8FA80010);
      check("lw_addr", out_addr, 32'h0);
      out_ready = 1'b1;
      step();
      check("j_inst", out_inst, 32'h08100000);
      check("j_addr", out_addr, 32'h4);
      check("j_count", 32'(count), 32'd1);
      step();
      out_ready = 1'b0;
      check("lwj_drain_count", 32'(count), 32'd0);
      check("lwj_drain_addr", out_addr, 32'h8);

      // BLEZ drops rt
      do_reset();
      set_req(OP_BLEZ, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0);
      step();
      in_valid = 1'b0;
      check("blez_inst", out_inst, 32'h1880FFFF);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // encoding table streamed with out_ready held high
      do_reset();
      exp_addr  = 32'h0;
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_req(vec_op[i], 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h3ABCDEF);
         step();
         in_valid = 1'b0;
         check($sformatf("vec%0d_inst", i), out_inst, vec_exp[i]);
         check($sformatf("vec%0d_addr", i), out_addr, exp_addr);
         step();
         exp_addr = exp_addr + 32'd4;
      end
      out_ready = 1'b0;
      check("vec_end_count", 32'(count), 32'd0);
      check("vec_end_addr", out_addr, exp_addr);

      // fill to four with a fifth request pending, then pop and push together
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_req(OP_ADDI, 5'd0, 5'd0, 5'd0, 5'd0, 16'(i), 26'h0);
         step();
      end
      check("full_count", 32'(count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_head", out_inst, 32'h20000000);
      out_ready = 1'b1;
      step();
      check("full_pop_count", 32'(count), 32'd3);
      check("full_pop_head", out_inst, 32'h20000001);
      check("full_pop_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("pushpop_count", 32'(count), 32'd3);
      check("pushpop_head", out_inst, 32'h20000002);
      step();
      check("order_head3", out_inst, 32'h20000003);
      step();
      check("order_head4", out_inst, 32'h20000004);
      check("order_addr", out_addr, 32'h10);
      step();
      out_ready = 1'b0;
      check("order_drain_count", 32'(count), 32'd0);

      // illegal op: one-cycle err, nothing buffered
      do_reset();
      in_valid = 1'b1;
      in_op    = OP_ILLEGAL;
      step();
      in_valid = 1'b0;
      check("ill_err_hi", 32'(err), 32'd1);
      check("ill_count", 32'(count), 32'd0);
      check("ill_out_valid", 32'(out_valid), 32'd0);
      step();
      check("ill_err_lo", 32'(err), 32'd0);
      check("ill_count2", 32'(count), 32'd0);

      // reset while three words are buffered and the address is at 8
      do_reset();
      set_req(OP_ORI, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0);
      step();
      set_req(OP_ORI, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0002, 26'h0);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      check("mid_addr8", out_addr, 32'h8);
      for (int i = 0; i < 3; i++) begin
         set_req(OP_ORI, 5'd2, 5'd2, 5'd0, 5'd0, 16'(16'h10 + i), 26'h0);
         step();
      end
      in_valid = 1'b0;
      check("mid_count3", 32'(count), 32'd3);
      reset     = 1'b1;
      out_ready = 1'b1;
      set_req(OP_ORI, 5'd3, 5'd3, 5'd0, 5'd0, 16'hBEEF, 26'h0);
      step();
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_addr", out_addr, 32'h0);
      check("mid_rst_inst", out_inst, 32'h0);
      set_req(OP_ORI, 5'd4, 5'd5, 5'd0, 5'd0, 16'h00AA, 26'h0);
      step();
      in_valid = 1'b0;
      check("post_rst_inst", out_inst, 32'h348500AA);
      check("post_rst_addr", out_addr, 32'h0);
      check("post_rst_valid", 32'(out_valid), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
